// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin arbiter.
// Optional hold timeout is enabled by defining RR_ARB_TIMEOUT_EN.
package arb_pkg;
    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 15;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/dec3to8_en.sv
// 3-to-8 decoder with enable; a is the MSB of the select, outputs all low when e=0.
module dec3to8_en (
    input  logic e,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7
);
    logic [2:0] w_sel;

    assign w_sel = {a, b, c};

    assign d0 = e && (w_sel == 3'd0);
    assign d1 = e && (w_sel == 3'd1);
    assign d2 = e && (w_sel == 3'd2);
    assign d3 = e && (w_sel == 3'd3);
    assign d4 = e && (w_sel == 3'd4);
    assign d5 = e && (w_sel == 3'd5);
    assign d6 = e && (w_sel == 3'd6);
    assign d7 = e && (w_sel == 3'd7);
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant held until done or request drop.
// Define RR_ARB_TIMEOUT_EN to force release after MAX_HOLD+1 grant cycles.
module rr_arbiter8
    import arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);
    // Handshake: a requester holds req[i] high until served; the owner keeps
    // req high while it uses the resource and ends the grant with a done pulse
    // or by dropping req. done is ignored outside GRANT.

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_release;
`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
`endif

    // First set request strictly after p, wrapping; index arithmetic wraps mod 8.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = p + IDX_W'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_release = done || !req[r_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
`ifdef RR_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_hold_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req != '0) begin
                    w_idx_nxt   = rr_pick(req, r_ptr);
                    w_ptr_nxt   = w_idx_nxt;
                    w_state_nxt = ST_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
`ifdef RR_ARB_TIMEOUT_EN
                end else if (r_hold_cnt == CNT_W'(MAX_HOLD)) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_nxt = r_hold_cnt + 1'b1;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_ptr      <= w_ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold_cnt <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

    // gnt_valid is the FSM state itself, so it doubles as the state debug view.
    assign gnt_valid = (r_state == ST_GRANT);
    assign gnt_idx   = r_idx;
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout   = r_timeout;
`endif

    dec3to8_en u_dec (
        .e  (gnt_valid),
        .a  (r_idx[2]),
        .b  (r_idx[1]),
        .c  (r_idx[0]),
        .d0 (gnt[0]),
        .d1 (gnt[1]),
        .d2 (gnt[2]),
        .d3 (gnt[3]),
        .d4 (gnt[4]),
        .d5 (gnt[5]),
        .d6 (gnt[6]),
        .d7 (gnt[7])
    );
endmodule
